// File: rtl/jr_redirect_ctrl_if.sv
// Bundle of ID-decode, hazard-source and PC-redirect signals around jr_redirect_ctrl.
// With JRCTRL_JALR_EN defined it also carries id_rd, link_we and link_rd.
interface jr_redirect_ctrl_if #(
    parameter int ALUOP_W = 2,
    parameter int FUNCT_W = 6,
    parameter int REG_W   = 5,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 16
);
    logic               id_valid;
    logic [ALUOP_W-1:0] ALUOp;
    logic [FUNCT_W-1:0] Function;
    logic [REG_W-1:0]   id_rs;
    logic [ADDR_W-1:0]  rs_data_rf;
    logic               ex_regwrite;
    logic               ex_memread;
    logic [REG_W-1:0]   ex_rd;
    logic               mem_regwrite;
    logic               mem_memread;
    logic [REG_W-1:0]   mem_rd;
    logic [ADDR_W-1:0]  mem_alu_result;
    logic               wb_regwrite;
    logic [REG_W-1:0]   wb_rd;
    logic [ADDR_W-1:0]  wb_data;
    logic               ext_flush;
    logic               stall;
    logic               pc_sel;
    logic [ADDR_W-1:0]  jr_target;
    logic               flush_ifid;
    logic [CNT_W-1:0]   redirect_cnt;
`ifdef JRCTRL_JALR_EN
    logic [REG_W-1:0]   id_rd;
    logic               link_we;
    logic [REG_W-1:0]   link_rd;
`endif

    modport master (
`ifdef JRCTRL_JALR_EN
        output id_rd, input link_we, input link_rd,
`endif
        output id_valid, ALUOp, Function, id_rs, rs_data_rf,
        output ex_regwrite, ex_memread, ex_rd,
        output mem_regwrite, mem_memread, mem_rd, mem_alu_result,
        output wb_regwrite, wb_rd, wb_data, ext_flush,
        input  stall, pc_sel, jr_target, flush_ifid, redirect_cnt
    );

    modport slave (
`ifdef JRCTRL_JALR_EN
        input id_rd, output link_we, output link_rd,
`endif
        input  id_valid, ALUOp, Function, id_rs, rs_data_rf,
        input  ex_regwrite, ex_memread, ex_rd,
        input  mem_regwrite, mem_memread, mem_rd, mem_alu_result,
        input  wb_regwrite, wb_rd, wb_data, ext_flush,
        output stall, pc_sel, jr_target, flush_ifid, redirect_cnt
    );
endinterface

// File: rtl/jr_redirect_ctrl.sv
// JR decode in ID, rs hazard stall, forwarded target select and registered one-cycle
// PC redirect with optional IF/ID flush. Define JRCTRL_JALR_EN to also decode JALR.
module jr_redirect_ctrl #(
    parameter int ALUOP_W    = 2,
    parameter int FUNCT_W    = 6,
    parameter int REG_W      = 5,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 16,
    parameter int DELAY_SLOT = 0
) (
    input  logic              clk,
    input  logic              reset,
    jr_redirect_ctrl_if.slave bus
);
    localparam logic [ALUOP_W-1:0] LP_ALUOP_R = ALUOP_W'(2'b10);
    localparam logic [FUNCT_W-1:0] LP_FN_JR   = FUNCT_W'(6'b001000);

    typedef enum logic [1:0] {ST_IDLE, ST_STALL, ST_REDIRECT} state_t;

    state_t            r_state;
    logic              r_pc_sel;
    logic              r_flush;
    logic [ADDR_W-1:0] r_target;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_rtype;
    logic              w_jalr;
    logic              w_jr_det;
    logic              w_rs_nz;
    logic              w_hazard;
    logic              w_busy;
    logic              w_enter;
    logic              w_unused_ex_memread;
    logic [ADDR_W-1:0] w_fwd;

    assign w_rtype  = bus.id_valid && (bus.ALUOp == LP_ALUOP_R);
`ifdef JRCTRL_JALR_EN
    localparam logic [FUNCT_W-1:0] LP_FN_JALR = FUNCT_W'(6'b001001);
    logic             r_pend_jalr;
    logic             r_link_we;
    logic [REG_W-1:0] r_link_rd;
    assign w_jalr       = w_rtype && (bus.Function == LP_FN_JALR);
    assign bus.link_we  = r_link_we && !bus.ext_flush;
    assign bus.link_rd  = r_link_rd;
`else
    assign w_jalr = 1'b0;
`endif
    assign w_jr_det = (w_rtype && (bus.Function == LP_FN_JR)) || w_jalr;

    // Any EX-stage writer of rs already stalls, so ex_memread adds nothing to the hazard.
    assign w_unused_ex_memread = bus.ex_memread;
    assign w_rs_nz  = (bus.id_rs != REG_W'(0));
    assign w_hazard = w_rs_nz &&
                      ((bus.ex_regwrite && (bus.ex_rd == bus.id_rs)) ||
                       (bus.mem_regwrite && bus.mem_memread && (bus.mem_rd == bus.id_rs)));

    always_comb begin
        w_fwd = bus.rs_data_rf;
        if (!w_rs_nz)
            w_fwd = '0;
        else if (bus.mem_regwrite && !bus.mem_memread && (bus.mem_rd == bus.id_rs))
            w_fwd = bus.mem_alu_result;
        else if (bus.wb_regwrite && (bus.wb_rd == bus.id_rs))
            w_fwd = bus.wb_data;
    end

    // A JR is being resolved this cycle: freshly detected in IDLE, or held in STALL.
    assign w_busy  = ((r_state == ST_IDLE) && w_jr_det) || (r_state == ST_STALL);
    assign w_enter = !bus.ext_flush && w_busy && !w_hazard;

    assign bus.stall        = reset && !bus.ext_flush && w_busy && w_hazard;
    assign bus.pc_sel       = r_pc_sel && !bus.ext_flush;
    assign bus.flush_ifid   = r_flush && !bus.ext_flush;
    assign bus.jr_target    = r_target;
    assign bus.redirect_cnt = r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_pc_sel <= 1'b0;
            r_flush  <= 1'b0;
            r_target <= '0;
            r_cnt    <= '0;
`ifdef JRCTRL_JALR_EN
            r_pend_jalr <= 1'b0;
            r_link_we   <= 1'b0;
            r_link_rd   <= '0;
`endif
        end else begin
            r_pc_sel <= 1'b0;
            r_flush  <= 1'b0;
`ifdef JRCTRL_JALR_EN
            r_link_we <= 1'b0;
`endif
            if (w_enter) begin
                r_state  <= ST_REDIRECT;
                r_pc_sel <= 1'b1;
                r_flush  <= (DELAY_SLOT == 0);
                r_target <= w_fwd;
                if (r_cnt != {CNT_W{1'b1}})
                    r_cnt <= r_cnt + CNT_W'(1);
`ifdef JRCTRL_JALR_EN
                r_link_we <= (r_state == ST_STALL) ? r_pend_jalr : w_jalr;
                r_link_rd <= bus.id_rd;
`endif
            end else if (bus.ext_flush || (r_state == ST_REDIRECT)) begin
                r_state <= ST_IDLE;
            end else if ((r_state == ST_IDLE) && w_jr_det) begin
                r_state <= ST_STALL;
`ifdef JRCTRL_JALR_EN
                r_pend_jalr <= w_jalr;
`endif
            end
        end
    end
endmodule

// File: doc/jr_redirect_ctrl.md
Name: jr_redirect_ctrl

Overview:
- Pipelined jump-register control unit for the 5-stage MIPS core; successor to the combinational JR decode.
- Decodes JR in ID and resolves hazards on the target register rs. Stalls when needed, selects the forwarded target and issues a registered one-cycle PC redirect with IF/ID flush.
- Sits between ID decode, the hazard unit and the PC mux. Parametrised in decode widths, address width and delay-slot mode.

Parameters:
- ALUOP_W, 2, ALUOp width
- FUNCT_W, 6, function field width
- REG_W, 5, register index width
- ADDR_W, 32, target/PC width
- CNT_W, 16, redirect counter width
- DELAY_SLOT, 0, 0 = flush IF/ID on redirect; 1 = no flush, delay slot executes

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a valid instruction
- ALUOp  in  ALUOP_W  ID ALUOp
- Function  in  FUNCT_W  ID funct field
- id_rs  in  REG_W  ID rs index
- rs_data_rf  in  ADDR_W  register-file rs value
- ex_regwrite, ex_memread  in  1 each  EX-stage controls
- ex_rd  in  REG_W  EX destination
- mem_regwrite, mem_memread  in  1 each  MEM-stage controls
- mem_rd  in  REG_W  MEM destination
- mem_alu_result  in  ADDR_W  MEM ALU result
- wb_regwrite  in  1  WB write enable
- wb_rd  in  REG_W  WB destination
- wb_data  in  ADDR_W  WB write data
- ext_flush  in  1  higher-priority flush (branch/exception)
- stall  out  1  hold PC and IF/ID, bubble into ID/EX
- pc_sel  out  1  select jr_target into PC
- jr_target  out  ADDR_W  registered jump target
- flush_ifid  out  1  flush IF/ID
- redirect_cnt  out  CNT_W  saturating count of issued redirects

Behaviour:
- jr_det = id_valid & ALUOp==2'b10 & Function==6'b001000.
- hazard = rs!=0 & ((ex_regwrite & ex_rd==rs) | (mem_regwrite & mem_memread & mem_rd==rs)).
- Forward select, in priority order:
  - MEM (mem_regwrite & ~mem_memread & mem_rd==rs & rs!=0)
  - else WB (wb_regwrite & wb_rd==rs & rs!=0)
  - else rs_data_rf
  - rs=0 always yields 0.
- FSM states: IDLE, STALL, REDIRECT.
- IDLE:
  - jr_det & ~hazard -> REDIRECT; jr_target latches the forwarded value.
  - jr_det & hazard -> STALL.
- STALL: re-evaluate hazard each cycle on the held instruction. Once it clears -> REDIRECT, latching the target.
- REDIRECT:
  - pc_sel=1 and flush_ifid=(DELAY_SLOT==0) for exactly one cycle; redirect_cnt increments, saturating at all-ones.
  - Next state is IDLE. Any jr_det in this cycle is ignored: that instruction is flushed or in the delay slot.
- stall is combinational: (IDLE & jr_det & hazard) | (STALL & hazard). It is 0 in REDIRECT.
- Latency:
  - No hazard: redirect in the cycle after ID detect.
  - ALU producer in EX: 1 stall cycle.
  - Load in EX: 2 stall cycles.
- ext_flush:
  - Forces the next state to IDLE and overrides the current cycle: pc_sel=0, stall=0.
  - No counter increment; jr_target is held.
- Reset low (any time, including mid-STALL or mid-REDIRECT):
  - Immediately IDLE; pc_sel, flush_ifid, stall=0; jr_target=0; redirect_cnt=0.
  - The first redirect is possible only after reset deasserts and a new jr_det occurs.
- jr_target holds its value outside REDIRECT.

Optional Feature:
- Macro: JRCTRL_JALR_EN.
- With the macro defined:
  - Function==6'b001001 (JALR) is also decoded, with identical stall and redirect behaviour.
  - Extra outputs: link_we (1 bit, high in REDIRECT for JALR only) and link_rd (REG_W bits, latched from new input id_rd at REDIRECT entry).
  - Both outputs reset to 0.
- Without the macro: JALR is not detected; the link_we, link_rd and id_rd ports do not exist.

Test Plan:
- JR rs=8, no hazard, rs_data_rf=0x00400020 -> next cycle pc_sel=1, jr_target=0x00400020, flush_ifid=1, stall=0; redirect_cnt=1.
- JR rs=8 with ex_regwrite=1, ex_memread=1, ex_rd=8 (load-use) -> stall=1 for 2 cycles. Then pc_sel=1 with target=wb_data=0x1000 (MEM load moved to WB).
- JR rs=9, mem_regwrite=1, mem_memread=0, mem_rd=9, mem_alu_result=0x2000; WB also writes r9=0x3000 -> no stall, jr_target=0x2000 (MEM priority).
- Enter STALL, then ext_flush=1 -> next cycle IDLE, pc_sel=0, stall=0, redirect_cnt unchanged. Repeat with reset pulsed low mid-STALL -> all outputs 0 asynchronously.
- DELAY_SLOT=1, two back-to-back JRs -> one redirect, flush_ifid=0, second JR ignored; CNT_W=2 with 5 redirects -> redirect_cnt saturates at 3.
- JRCTRL_JALR_EN defined, JALR rs=4, rd=31 -> REDIRECT with link_we=1, link_rd=31. Macro undefined -> same stimulus gives pc_sel=0.
